// File: rtl/acl_pkg.sv
// Shared definitions for the ADXL345-style SPI responder: register map,
// reset values, writability rule and FSM state encoding.
package acl_pkg;

  localparam logic [5:0] ADDR_DEVID       = 6'h00;
  localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;
  localparam logic [5:0] ADDR_DATAX1      = 6'h33;
  localparam logic [5:0] ADDR_DATAY0      = 6'h34;
  localparam logic [5:0] ADDR_DATAY1      = 6'h35;
  localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
  localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

  localparam logic [7:0] RST_BW_RATE = 8'h0A;
  localparam logic [7:0] RST_DEFAULT = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } acl_state_e;

  function automatic logic is_writable(input logic [5:0] addr);
    logic w;
    if ((addr >= 6'h1E) && (addr <= 6'h2A)) begin
      w = 1'b1;
    end else if ((addr >= 6'h2C) && (addr <= 6'h2F)) begin
      w = 1'b1;
    end else if ((addr == 6'h31) || (addr == 6'h38)) begin
      w = 1'b1;
    end else begin
      w = 1'b0;
    end
    return w;
  endfunction

  function automatic logic [7:0] reset_value(input logic [5:0] addr);
    return (addr == ADDR_BW_RATE) ? RST_BW_RATE : RST_DEFAULT;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer with rise/fall detection for one SPI pin.
// Edges are suppressed until the chain holds only post-reset samples.
module spi_pin_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_r;
  logic              prev_r;
  logic [STAGES:0]   fill_r;

  // Synchronizer chain, previous-level flop and fill tracker
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_r <= {STAGES{RST_VAL}};
      prev_r  <= RST_VAL;
      fill_r  <= {(STAGES+1){1'b0}};
    end else begin
      chain_r <= {chain_r[STAGES-2:0], din};
      prev_r  <= chain_r[STAGES-1];
      fill_r  <= {fill_r[STAGES-1:0], 1'b1};
    end
  end

  assign sync = chain_r[STAGES-1];
  assign rise = fill_r[STAGES] & sync & ~prev_r;
  assign fall = fill_r[STAGES] & ~sync & prev_r;

endmodule

// File: rtl/acl_spi_responder.sv
// SPI mode-3 slave emulating the ADXL345 register file, oversampled in clk.
// ACL_MULTIBYTE_EN enables the MB bit (address auto-increment, 0x3F wraps to 0x00).
module acl_spi_responder
  import acl_pkg::*;
#(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  input  logic        sample_valid,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  input  logic [15:0] z_in,
  output logic        reg_wr,
  output logic [5:0]  reg_addr,
  output logic [7:0]  reg_wdata,
  output logic [7:0]  power_ctl,
  output logic [7:0]  bw_rate,
  output logic [7:0]  data_format,
  output logic        busy
);

  logic sclk_sync_s, sclk_rise_s, sclk_fall_s;
  logic cs_sync_s, cs_rise_s, cs_fall_s;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic mosi_s, start_s;

  acl_state_e state_r, state_nxt_s;
  logic [2:0]  bit_cnt_r;
  logic [6:0]  rx_r;
  logic [7:0]  tx_r;
  logic [5:0]  addr_r;
  logic        rw_r;
`ifdef ACL_MULTIBYTE_EN
  logic        mb_r;
`endif
  logic        miso_r, reg_wr_r, busy_r;
  logic [5:0]  reg_addr_r;
  logic [7:0]  reg_wdata_r;
  logic [7:0]  reg_file_r [64];
  logic        pend_valid_r;
  logic [15:0] pend_x_r, pend_y_r, pend_z_r;
  logic [5:0]  cmd_addr_s, next_addr_s, rd_addr_s;
  logic [7:0]  rd_data_s;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(sclk),
    .sync(sclk_sync_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .din(cs_n),
    .sync(cs_sync_s), .rise(cs_rise_s), .fall(cs_fall_s)
  );

  // MOSI synchronizer, same depth so it stays aligned with sclk edges
  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
    end
  end

  assign mosi_s = mosi_sync_r[SYNC_STAGES-1];
  // Mode 3: a transaction only begins while sclk is at its idle-high level.
  assign start_s = cs_fall_s & sclk_sync_s;

  // Command address, next data-byte address and read-data mux
  always_comb begin
    cmd_addr_s = {rx_r[4:0], mosi_s};
`ifdef ACL_MULTIBYTE_EN
    next_addr_s = mb_r ? (addr_r + 6'd1) : addr_r;
`else
    next_addr_s = addr_r;
`endif
    rd_addr_s = (state_r == ST_CMD) ? cmd_addr_s : next_addr_s;
    rd_data_s = (rd_addr_s == ADDR_DEVID) ? DEVID : reg_file_r[rd_addr_s];
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_nxt_s = ST_CMD;
        else         state_nxt_s = ST_IDLE;
      end
      ST_CMD: begin
        if (cs_rise_s)                               state_nxt_s = ST_IDLE;
        else if (sclk_rise_s && (bit_cnt_r == 3'd7)) state_nxt_s = ST_DATA;
        else                                         state_nxt_s = ST_CMD;
      end
      ST_DATA: begin
        if (cs_rise_s) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_DATA;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Sample strobes arriving mid-transaction wait here until cs_n is released
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid_r <= 1'b0;
      pend_x_r     <= 16'h0000;
      pend_y_r     <= 16'h0000;
      pend_z_r     <= 16'h0000;
    end else if (sample_valid && busy_r) begin
      pend_valid_r <= 1'b1;
      pend_x_r     <= x_in;
      pend_y_r     <= y_in;
      pend_z_r     <= z_in;
    end else if (!busy_r) begin
      pend_valid_r <= 1'b0;
    end
  end

  // SPI shift datapath, register file, write strobe and busy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_r   <= 3'd0;
      rx_r        <= 7'h00;
      tx_r        <= 8'h00;
      addr_r      <= 6'h00;
      rw_r        <= 1'b0;
`ifdef ACL_MULTIBYTE_EN
      mb_r        <= 1'b0;
`endif
      miso_r      <= 1'b0;
      reg_wr_r    <= 1'b0;
      reg_addr_r  <= 6'h00;
      reg_wdata_r <= 8'h00;
      busy_r      <= 1'b0;
      for (int i = 0; i < 64; i++) begin
        reg_file_r[i] <= reset_value(6'(i));
      end
    end else begin
      reg_wr_r <= 1'b0;
      busy_r   <= ~cs_sync_s;

      if (sample_valid && !busy_r) begin
        reg_file_r[ADDR_DATAX0] <= x_in[7:0];
        reg_file_r[ADDR_DATAX1] <= x_in[15:8];
        reg_file_r[ADDR_DATAY0] <= y_in[7:0];
        reg_file_r[ADDR_DATAY1] <= y_in[15:8];
        reg_file_r[ADDR_DATAZ0] <= z_in[7:0];
        reg_file_r[ADDR_DATAZ1] <= z_in[15:8];
      end else if (pend_valid_r && !busy_r) begin
        reg_file_r[ADDR_DATAX0] <= pend_x_r[7:0];
        reg_file_r[ADDR_DATAX1] <= pend_x_r[15:8];
        reg_file_r[ADDR_DATAY0] <= pend_y_r[7:0];
        reg_file_r[ADDR_DATAY1] <= pend_y_r[15:8];
        reg_file_r[ADDR_DATAZ0] <= pend_z_r[7:0];
        reg_file_r[ADDR_DATAZ1] <= pend_z_r[15:8];
      end

      case (state_r)
        ST_IDLE: begin
          miso_r <= 1'b0;
          if (start_s) begin
            bit_cnt_r <= 3'd0;
            tx_r      <= 8'h00;
          end
        end
        ST_CMD: begin
          if (cs_rise_s) begin
            miso_r <= 1'b0;
          end else if (sclk_rise_s) begin
            rx_r      <= {rx_r[5:0], mosi_s};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              rw_r   <= rx_r[6];
`ifdef ACL_MULTIBYTE_EN
              mb_r   <= rx_r[5];
`endif
              addr_r <= cmd_addr_s;
              tx_r   <= rx_r[6] ? rd_data_s : 8'h00;
            end
          end
        end
        ST_DATA: begin
          if (cs_rise_s) begin
            miso_r <= 1'b0;
          end else begin
            if (sclk_fall_s) begin
              miso_r <= tx_r[7];
              tx_r   <= {tx_r[6:0], 1'b0};
            end
            if (sclk_rise_s) begin
              rx_r      <= {rx_r[5:0], mosi_s};
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                if (rw_r) begin
                  tx_r <= rd_data_s;
                end else if (is_writable(addr_r)) begin
                  reg_file_r[addr_r] <= {rx_r, mosi_s};
                  reg_wr_r           <= 1'b1;
                  reg_addr_r         <= addr_r;
                  reg_wdata_r        <= {rx_r, mosi_s};
                end
                addr_r <= next_addr_s;
              end
            end
          end
        end
        default: miso_r <= 1'b0;
      endcase
    end
  end

  assign miso        = miso_r;
  assign reg_wr      = reg_wr_r;
  assign reg_addr    = reg_addr_r;
  assign reg_wdata   = reg_wdata_r;
  assign busy        = busy_r;
  assign power_ctl   = reg_file_r[ADDR_POWER_CTL];
  assign bw_rate     = reg_file_r[ADDR_BW_RATE];
  assign data_format = reg_file_r[ADDR_DATA_FORMAT];

endmodule

// File: tb/tb_acl_spi_responder.sv
// Self-checking bench for acl_spi_responder: directed scenarios plus random
// transactions compared against an array-based model of the register map.
module tb_acl_spi_responder;

  localparam int HALF = 6;
`ifdef ACL_MULTIBYTE_EN
  localparam bit MB_EN = 1'b1;
`else
  localparam bit MB_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, sclk = 1'b1, cs_n = 1'b1, mosi = 1'b0, sample_valid = 1'b0;
  logic [15:0] x_in = 16'h0, y_in = 16'h0, z_in = 16'h0;
  logic miso, reg_wr, busy;
  logic [5:0] reg_addr;
  logic [7:0] reg_wdata, power_ctl, bw_rate, data_format;

  int checks = 0, errors = 0;
  int wr_seen = 0;
  logic [5:0] wr_addr_seen = 6'h0;
  logic [7:0] wr_data_seen = 8'h0;

  logic [7:0] model [64];
  bit in_txn = 1'b0, pend_v = 1'b0;
  logic [15:0] pend_x, pend_y, pend_z;

  always #5 clk = ~clk;

  acl_spi_responder #(.DEVID(8'hE5), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .sample_valid(sample_valid), .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .power_ctl(power_ctl), .bw_rate(bw_rate), .data_format(data_format), .busy(busy)
  );

  always @(negedge clk) begin
    if (reg_wr === 1'b1) begin
      wr_seen++;
      wr_addr_seen = reg_addr;
      wr_data_seen = reg_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit tb_writable(input int a);
    return ((a >= 30) && (a <= 42)) || ((a >= 44) && (a <= 47)) || (a == 49) || (a == 56);
  endfunction

  function automatic logic [7:0] model_rd(input int a);
    return (a == 0) ? 8'hE5 : model[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) model[i] = 8'h00;
    model[44] = 8'h0A;
    pend_v = 1'b0;
  endtask

  task automatic model_load(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    model[50] = x[7:0]; model[51] = x[15:8];
    model[52] = y[7:0]; model[53] = y[15:8];
    model[54] = z[7:0]; model[55] = z[15:8];
  endtask

  task automatic strobe(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk);
    sample_valid = 1'b1; x_in = x; y_in = y; z_in = z;
    @(negedge clk);
    sample_valid = 1'b0;
    if (in_txn) begin
      pend_v = 1'b1; pend_x = x; pend_y = y; pend_z = z;
    end else begin
      model_load(x, y, z);
    end
  endtask

  // Mode 3 bit transfer: master drives mosi on the fall, samples miso just before the rise.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      sclk = 1'b0;
      mosi = tx[7-i];
      repeat (HALF) @(negedge clk);
      rx[7-i] = miso;
      sclk = 1'b1;
      repeat (HALF - 1) @(negedge clk);
    end
  endtask

  task automatic txn(input string tag, input logic [7:0] cmd, input int nbytes, input int strobe_at,
                     input logic [15:0] sx, input logic [15:0] sy, input logic [15:0] sz);
    logic [7:0] rx, d;
    logic [5:0] exp_a;
    logic [7:0] exp_d;
    int a, wr_before, exp_wr;
    wr_before = wr_seen; exp_wr = 0; exp_a = 6'h0; exp_d = 8'h0;
    in_txn = 1'b1;
    @(negedge clk) cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bits(cmd, 8, rx);
    a = int'(cmd[5:0]);
    for (int k = 0; k < nbytes; k++) begin
      if (k == strobe_at) strobe(sx, sy, sz);
      d = cmd[7] ? 8'h00 : 8'($urandom);
      spi_bits(d, 8, rx);
      if (cmd[7]) begin
        chk($sformatf("%s rd%0d @%02h", tag, k, a), {24'h0, rx}, {24'h0, model_rd(a)});
      end else if (tb_writable(a)) begin
        model[a] = d; exp_wr++; exp_a = 6'(a); exp_d = d;
      end
      if (MB_EN && cmd[6]) a = (a + 1) % 64;
    end
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    in_txn = 1'b0;
    repeat (10) @(negedge clk);
    if (pend_v) begin
      model_load(pend_x, pend_y, pend_z);
      pend_v = 1'b0;
    end
    chk({tag, " wr_count"}, wr_seen - wr_before, exp_wr);
    if (exp_wr > 0) begin
      chk({tag, " reg_addr"}, {26'h0, wr_addr_seen}, {26'h0, exp_a});
      chk({tag, " reg_wdata"}, {24'h0, wr_data_seen}, {24'h0, exp_d});
    end
    chk({tag, " power_ctl"}, {24'h0, power_ctl}, {24'h0, model[45]});
    chk({tag, " bw_rate"}, {24'h0, bw_rate}, {24'h0, model[44]});
    chk({tag, " data_format"}, {24'h0, data_format}, {24'h0, model[49]});
  endtask

  initial begin
    logic [7:0] rx;
    int wr_before;
    model_reset();
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("reset miso", {31'h0, miso}, 32'h0);
    chk("reset reg_wr", {31'h0, reg_wr}, 32'h0);
    chk("reset busy", {31'h0, busy}, 32'h0);
    chk("reset power_ctl", {24'h0, power_ctl}, 32'h00);
    chk("reset bw_rate", {24'h0, bw_rate}, 32'h0A);
    chk("reset data_format", {24'h0, data_format}, 32'h00);

    txn("devid", 8'h80, 1, -1, 16'h0, 16'h0, 16'h0);
    txn("wr power_ctl", 8'h2D, 1, -1, 16'h0, 16'h0, 16'h0);
    txn("rd power_ctl", 8'hAD, 1, -1, 16'h0, 16'h0, 16'h0);
    strobe(16'h1234, 16'hABCD, 16'h0001);
    txn("samples", 8'hF2, 6, -1, 16'h0, 16'h0, 16'h0);
    txn("mid-read sample", 8'hF2, 6, 2, 16'h5555, 16'hABCD, 16'h0001);
    txn("after sample", 8'hF2, 2, -1, 16'h0, 16'h0, 16'h0);

    // Partial data byte to DATA_FORMAT must leave it untouched.
    wr_before = wr_seen;
    @(negedge clk) cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bits(8'h31, 8, rx);
    spi_bits(8'hFF, 5, rx);
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("partial wr_count", wr_seen - wr_before, 0);
    chk("partial data_format", {24'h0, data_format}, {24'h0, model[49]});
    txn("wr devid ignored", 8'h00, 1, -1, 16'h0, 16'h0, 16'h0);

    // Reset in the middle of a DEVID read; trailing clocks must be ignored.
    wr_before = wr_seen;
    @(negedge clk) cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bits(8'h80, 8, rx);
    spi_bits(8'h00, 3, rx);
    rst = 1'b1;
    @(negedge clk);
    chk("rst miso", {31'h0, miso}, 32'h0);
    chk("rst busy", {31'h0, busy}, 32'h0);
    chk("rst reg_wr", {31'h0, reg_wr}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    spi_bits(8'h00, 5, rx);
    chk("post-rst tail miso", {24'h0, rx}, 32'h0);
    spi_bits(8'h2D, 8, rx);
    chk("post-rst cmd miso", {24'h0, rx}, 32'h0);
    spi_bits(8'hFF, 8, rx);
    chk("post-rst data miso", {24'h0, rx}, 32'h0);
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post-rst wr_count", wr_seen - wr_before, 0);
    chk("post-rst power_ctl", {24'h0, power_ctl}, 32'h00);
    txn("post-rst bw_rate", 8'hAC, 1, -1, 16'h0, 16'h0, 16'h0);
    txn("wrap 3f", 8'hFF, 2, -1, 16'h0, 16'h0, 16'h0);

    for (int it = 0; it < 36; it++) begin
      int kind, nb, sa;
      logic [7:0] c;
      logic [5:0] wa [6];
      wa[0] = 6'h2D; wa[1] = 6'h2C; wa[2] = 6'h31; wa[3] = 6'h38; wa[4] = 6'h1E; wa[5] = 6'h2A;
      kind = $urandom_range(0, 3);
      c = 8'($urandom);
      nb = $urandom_range(1, 3);
      sa = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nb - 1) : -1;
      if (kind == 0) strobe(16'($urandom), 16'($urandom), 16'($urandom));
      if (kind == 1) begin
        c[7] = 1'b0;
        c[5:0] = wa[$urandom_range(0, 5)];
      end
      if (kind == 2) begin
        c[7] = 1'b1;
        c[5:0] = 6'($urandom_range(44, 56));
      end
      txn($sformatf("rnd%0d cmd%02h", it, c), c, nb, sa,
          16'($urandom), 16'($urandom), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acl_spi_responder.md
# acl_spi_responder

SPI slave that emulates the ADXL345 accelerometer register interface (4-wire, SPI mode 3) so the existing SPI master controller can be exercised in simulation and on-board loopback without a physical PmodACL. It sits on the PMOD pins, runs entirely in the 100 MHz `clk` domain by oversampling `sclk`/`cs_n`/`mosi`, and exposes axis-sample inputs plus decoded configuration-register outputs.

## Interface
- `DEVID`, default 8'hE5: value returned by register 0x00.
- `SYNC_STAGES`, default 2: synchronizer depth on `sclk`, `cs_n` and `mosi`; minimum 2.
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: reset, synchronous, active-high.
- `sclk` in 1: SPI clock from the master, idles high.
- `cs_n` in 1: chip select, active-low.
- `mosi` in 1: master-to-slave data, MSB first.
- `miso` out 1: slave-to-master data, MSB first.
- `sample_valid` in 1: single-cycle strobe; loads a new axis sample.
- `x_in`, `y_in`, `z_in` in 16 each: signed axis samples.
- `reg_wr` out 1: one-cycle pulse on every accepted register write.
- `reg_addr` out 6: address of the accepted write; valid with `reg_wr`.
- `reg_wdata` out 8: data of the accepted write; valid with `reg_wr`.
- `power_ctl`, `bw_rate`, `data_format` out 8 each: live contents of 0x2D, 0x2C and 0x31.
- `busy` out 1: high while synchronized `cs_n` is low.

## Operation
- Inputs pass through `SYNC_STAGES` flops. `sclk` rising and falling edges are detected one cycle after synchronization.
- Command byte format: bit7 is R/W (1 = read), bit6 is MB (multi-byte), bits5:0 are the address.
- State machine:
  - IDLE: `miso` = 0. A synced `cs_n` falling edge moves to CMD, clears the 3-bit bit counter, and preloads the tx shift register with 0.
  - CMD: `mosi` is sampled on each rising edge. On the 8th rising edge, rw/mb/addr are latched and the FSM moves to DATA. For a read, the tx shift register is loaded with reg[addr] in the same cycle.
  - DATA: `miso` updates on every falling edge from tx[7] and then shifts. `mosi` is sampled on rising edges. On each 8th rising edge:
    - Write: the rx byte goes to reg[addr] if addr is writable, and `reg_wr` pulses.
    - Read: reg[next addr] is loaded into tx.
    - Next address is addr+1 (mod 64) when mb=1, otherwise addr is unchanged.
  - A synced `cs_n` rising edge from any state returns to IDLE. A partial byte is discarded with no write and no `reg_wr`.
- Register map: 64×8.
  - 0x00 returns `DEVID`.
  - 0x32–0x37 hold DATAX0, X1, Y0, Y1, Z0, Z1, little-endian (low byte at the even address).
  - Writable: 0x1E–0x2A, 0x2C–0x2F, 0x31, 0x38. Writes to any other address are ignored and produce no `reg_wr`.
  - Reset values: 0x2C = 0x0A, all others 0x00 (DEVID is constant).
- Sample loading:
  - `sample_valid` while not `busy` updates 0x32–0x37 on the next cycle.
  - `sample_valid` while `busy` is held in a one-deep pending buffer, applied the cycle after `busy` falls. A newer strobe overwrites the pending one.
  - This keeps multi-byte reads coherent.
- `rst`, synchronously: FSM to IDLE, registers to reset values, pending buffer cleared, `miso` = 0, `reg_wr` = 0, `busy` = 0. A transaction in flight is aborted, and the responder waits for a fresh `cs_n` falling edge.

## Timing
- Input-to-action latency: `SYNC_STAGES`+1 clk after a pin edge.
- Required: `sclk` high and low phases each ≥ `SYNC_STAGES`+2 clk periods; `cs_n` setup to the first `sclk` fall ≥ `SYNC_STAGES`+2 clk.
- `miso` changes `SYNC_STAGES`+1 clk after `sclk` falls, so it is stable well before the next rise.
- `reg_wr`, `reg_addr` and `reg_wdata` are registered, asserted one clk after the 8th rising edge is detected. The register update and the `power_ctl`/`bw_rate`/`data_format` outputs change in that same cycle.
- `busy` follows synced `cs_n` with 1 clk latency.

## Configuration
- `ACL_MULTIBYTE_EN` defined: MB bit honoured, address auto-increments with wrap 0x3F→0x00.
- `ACL_MULTIBYTE_EN` undefined: MB bit ignored. Every data byte uses the command address, so repeated reads return the same register and repeated writes rewrite it.

## Structure
- Package `acl_pkg`:
  - register address constants (DEVID, BW_RATE, POWER_CTL, DATA_FORMAT, DATAX0–DATAZ1);
  - reset-value constants;
  - an `is_writable(addr)` function;
  - the FSM state typedef (IDLE, CMD, DATA).
- Sub-module `spi_pin_sync`: a parameterized synchronizer plus rise/fall edge detector, instantiated for `sclk` and `cs_n`. `mosi` uses its synchronizer output only.

## Test plan
- Read 0x80 (DEVID) → `miso` byte after the command = 0xE5, no `reg_wr`.
- Write 0x2D with 0x08 → `reg_wr` pulse with addr 0x2D and data 0x08; `power_ctl` = 0x08; read-back of 0xAD = 0x08.
- `sample_valid` with x = 0x1234, y = 0xABCD, z = 0x0001, then read 0xF2 for six bytes → 34 12 CD AB 01 00. Without `ACL_MULTIBYTE_EN` → 34 repeated.
- `sample_valid` with x = 0x5555 mid-read of 0xF2 → the in-flight bytes keep the old value; the next read returns 55 55.
- `cs_n` raised after 5 bits of a write data byte to 0x31 → `data_format` unchanged, no `reg_wr`. Write to 0x00 → ignored.
- `rst` asserted mid-transaction → `miso` = 0, 0x2C reads 0x0A, the remaining `sclk` edges are ignored until a new `cs_n` fall. MB read from 0x3F → the second byte comes from 0x00.
